// File: rtl/module_counter_pkg.sv
// Shared types and helpers for the prescaled 6-bit event counter.
package module_counter_pkg;

    localparam int COUNT_W = 6;

    typedef logic [COUNT_W-1:0] count_t;

    localparam count_t COUNT_ZERO = 6'd0;
    localparam count_t COUNT_ONE  = 6'd1;

    // Prescaler register width: enough bits for 0..prescale-1, never below one bit.
    function automatic int prescale_width(input int prescale);
        if (prescale > 1) begin
            return $clog2(prescale);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/module_counter_prescaler.sv
// Free-running divide-by-PRESCALE counter producing a one-cycle tick on its last state.
module module_counter_prescaler
    import module_counter_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int              PRE_W    = prescale_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // A prescale of zero or below has no meaningful divide ratio.
    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("module_counter_prescaler: PRESCALE must be >= 1 (got %0d)", PRESCALE);
        end
    endgenerate

    logic [PRE_W-1:0] presc_r;
    logic [PRE_W-1:0] presc_next_s;
    logic             tick_s;

    // Tick on the last prescaler state, then wrap to zero; with PRESCALE=1 the
    // register stays at zero and the tick is permanently high.
    always_comb begin
        tick_s       = (presc_r == PRE_LAST);
        presc_next_s = presc_r;
        if (tick_s) begin
            presc_next_s = PRE_ZERO;
        end else begin
            presc_next_s = presc_r + PRE_ONE;
        end
    end

    // Prescaler state register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= PRE_ZERO;
        end else begin
            presc_r <= presc_next_s;
        end
    end

    assign tick_o = tick_s;

endmodule

// File: rtl/module_counter.sv
// Six-bit wrapping counter advanced once every PRESCALE clock cycles.
module module_counter
    import module_counter_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic   clk,
    input  logic   rst,
    output count_t count_o
);

    logic   tick_s;
    count_t count_r;
    count_t count_next_s;

    module_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_s)
    );

    // Advance on tick; natural 6-bit overflow gives the 63 -> 0 wrap.
    always_comb begin
        count_next_s = count_r;
        if (tick_s) begin
            count_next_s = count_r + COUNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= COUNT_ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count_o = count_r;

endmodule

// File: tb/tb_module_counter.sv
// Scoreboard bench: two instances (PRESCALE=10 and PRESCALE=1) share clock and reset.
module tb_module_counter;

    logic       clk;
    logic       rst;
    logic [5:0] count_p10;
    logic [5:0] count_p1;

    int n_checks = 0;
    int n_pass   = 0;
    int edges    = 0;

    logic [5:0] exp_q10[$];
    logic [5:0] exp_q1[$];

    module_counter #(.PRESCALE(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .count_o (count_p10)
    );

    module_counter #(.PRESCALE(1)) dut_p1 (
        .clk     (clk),
        .rst     (rst),
        .count_o (count_p1)
    );

    // 20 ns clock, rising edges at 10, 30, 50 ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", tag, obs, exp, edges, $time);
        end
    endtask

    task automatic check_both_zero(input string tag);
        check_val({tag, "_p10"}, count_p10, 6'd0);
        check_val({tag, "_p1"},  count_p1,  6'd0);
    endtask

    // Apply n clock edges; the model pushes the expected counts at each edge and
    // the scoreboard pops and compares them half a cycle later.
    task automatic run_edges(input int n);
        logic [5:0] e10;
        logic [5:0] e1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edges++;
            exp_q10.push_back(6'((edges / 10) % 64));
            exp_q1.push_back(6'(edges % 64));
            @(negedge clk);
            e10 = exp_q10.pop_front();
            e1  = exp_q1.pop_front();
            if (edges == 9 || edges == 10 || edges == 20 || edges == 630 || edges == 640) begin
                check_val($sformatf("p10_edge%0d", edges), count_p10, e10);
            end else begin
                check_val("cnt_p10", count_p10, e10);
            end
            if (edges == 64) begin
                check_val("p1_wrap_edge64", count_p1, e1);
            end else begin
                check_val("cnt_p1", count_p1, e1);
            end
            check_val("no_x_p10", {5'd0, $isunknown(count_p10)}, 6'd0);
        end
    endtask

    initial begin
        rst = 1'b1;

        // Reset held with clock running: zero at and between edges.
        #1;  check_both_zero("rst_t1");
        #14; check_both_zero("rst_t15");
        #10; check_both_zero("rst_t25");
        #10; check_both_zero("rst_t35");

        // Release away from an active edge (t=40, falling edge).
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        #1; check_both_zero("release");

        // First increment at edge 10, wrap at 640, then stop with count_o = 5.
        run_edges(693);
        check_val("pre_reset_p10", count_p10, 6'd5);

        // Asynchronous reset mid-cycle clears immediately.
        #2;  rst = 1'b1;
        #1;  check_both_zero("async_rst");
        @(posedge clk);
        #1;  check_both_zero("rst_hold_edge");
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        #1;  check_both_zero("rerelease");

        // Long continuous run against floor(edges/10) mod 64.
        run_edges(15000);

        check_val("queue_empty", 6'(exp_q10.size() + exp_q1.size()), 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
